ctrl_pipe: RTL and testbench

Parametrised successor to the single-register control unit. Decodes the instruction opcode into the 8-bit control rod, then carries each control word, with a valid bit, through a configurable chain of pipeline stages. Supports a decode stall with bubble insertion, a branch flush of the younger stages, illegal-opcode detection, and retire/bubble performance counters. Sits between instruction fetch and the EX/MEM/WB datapath; stage k output drives the datapath stage k.

---
 rtl/ctrl_pipe_if.sv | 27 ++
 rtl/ctrl_pipe.sv | 114 +++++++++++
 tb/tb_ctrl_pipe.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Decode/pipeline control bus: fetch-side handshake inputs and per-stage control outputs.
interface ctrl_pipe_if #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned CNT_W    = 16
);
    logic                  in_valid;
    logic [OPCODE_W-1:0]   opcode;
    logic                  stall;
    logic                  flush;
    logic                  in_ready;
    logic [STAGES*8-1:0]   ctrl_stage;
    logic [STAGES-1:0]     valid_stage;
    logic                  illegal;
    logic [CNT_W-1:0]      retired_cnt;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output in_valid, opcode, stall, flush,
        input  in_ready, ctrl_stage, valid_stage, illegal, retired_cnt, bubble_cnt
    );

    modport slave (
        input  in_valid, opcode, stall, flush,
        output in_ready, ctrl_stage, valid_stage, illegal, retired_cnt, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Opcode decoder feeding a chain of control-word pipeline stages with stall,
// flush, illegal-opcode pulse and retire/bubble counters.
module ctrl_pipe #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    // {legal, ctrl}; any nonzero bit above [3] makes the opcode illegal
    function automatic logic [8:0] decode(input logic [OPCODE_W-1:0] op);
        logic [8:0] r;
        r = 9'h000;
        if ((op >> 4) == '0) begin
            case (op[3:0])
                4'b0000: r = 9'h100;
                4'b0001: r = 9'h101;
                4'b0010: r = 9'h102;
                4'b0011: r = 9'h103;
                4'b0100: r = 9'h104;
                4'b0110: r = 9'h106;
                4'b1011: r = 9'h108;
                4'b1111: r = 9'h180;
                4'b1101: r = 9'h150;
                4'b1010: r = 9'h120;
                4'b1100: r = 9'h140;
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    logic [7:0]        ctrl_q [STAGES];
    logic [7:0]        ctrl_d [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic [CNT_W-1:0]  squash;
    logic [8:0]        dec;

    always_comb begin
        dec       = decode(bus.opcode);
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        squash    = '0;
        retired_d = retired_q + CNT_W'(valid_q[STAGES-1]);

        for (int unsigned k = 1; k < STAGES; k++) begin
            ctrl_d[k]  = ctrl_q[k-1];
            valid_d[k] = valid_q[k-1];
        end

        if (bus.flush) begin
            // Stage FLUSH_DEPTH bubbles too: its feeder was squashed. The word in
            // the last stage leaves anyway and is counted as retired, not squashed.
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (k <= FLUSH_DEPTH) begin
                    ctrl_d[k]  = '0;
                    valid_d[k] = 1'b0;
                end
                if (k < FLUSH_DEPTH && k < STAGES - 1) begin
                    squash = squash + CNT_W'(valid_q[k]);
                end
            end
        end else if (bus.stall) begin
            ctrl_d[0]  = ctrl_q[0];
            valid_d[0] = valid_q[0];
            ctrl_d[1]  = '0;
            valid_d[1] = 1'b0;
            squash     = CNT_W'(valid_q[0]);
        end else begin
            valid_d[0] = bus.in_valid && dec[8];
            ctrl_d[0]  = valid_d[0] ? dec[7:0] : '0;
            illegal_d  = bus.in_valid && !dec[8];
        end

        bubble_d = bubble_q + squash;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '{default: '0};
            valid_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    always_comb begin
        bus.ctrl_stage = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            bus.ctrl_stage[8*k +: 8] = ctrl_q[k];
        end
        bus.valid_stage = valid_q;
        bus.illegal     = illegal_q;
        bus.retired_cnt = retired_q;
        bus.bubble_cnt  = bubble_q;
        bus.in_ready    = !bus.stall || bus.flush;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: a token-list model of in-flight instructions
// predicts each cycle's outputs and the retirement order.
module tb_ctrl_pipe;
    localparam int unsigned OW = 4;
    localparam int unsigned S  = 3;
    localparam int unsigned FD = 2;
    localparam int unsigned CW = 16;

    typedef struct {
        logic [7:0]  c;
        int unsigned pos;
    } tok_t;

    typedef struct {
        logic [S*8-1:0] ctrl;
        logic [S-1:0]   vld;
        logic           ill;
        logic [CW-1:0]  ret;
        logic [CW-1:0]  bub;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    ctrl_pipe_if #(.OPCODE_W(OW), .STAGES(S), .CNT_W(CW)) bus ();

    ctrl_pipe #(.OPCODE_W(OW), .STAGES(S), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction set table: -1 marks an illegal opcode
    int dec_tab [16] = '{'h00, 'h01, 'h02, 'h03, 'h04, -1, 'h06, -1,
                         -1, -1, 'h20, 'h08, 'h40, 'h50, -1, 'h80};

    tok_t          pipe_q [$];
    snap_t         snap_q [$];
    logic [7:0]    retire_q [$];
    logic [CW-1:0] m_ret = '0;
    logic [CW-1:0] m_bub = '0;
    logic          m_ill = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic model_step();
        tok_t  nq [$];
        tok_t  t;
        snap_t s;
        int    d;
        logic  accept;
        if (rst) begin
            pipe_q.delete();
            m_ret = '0;
            m_bub = '0;
            m_ill = 1'b0;
        end else begin
            d      = dec_tab[bus.opcode];
            accept = !bus.flush && !bus.stall;
            foreach (pipe_q[i]) begin
                t = pipe_q[i];
                if (t.pos == S - 1) begin
                    m_ret++;
                end else if (bus.flush && t.pos < FD) begin
                    m_bub++;
                end else if (!bus.flush && bus.stall && t.pos == 0) begin
                    m_bub++;
                    nq.push_back(t);
                end else begin
                    t.pos++;
                    nq.push_back(t);
                end
            end
            if (accept && bus.in_valid && d >= 0) nq.push_back('{c: 8'(d), pos: 0});
            m_ill  = accept && bus.in_valid && d < 0;
            pipe_q = nq;
        end
        s.ctrl = '0;
        s.vld  = '0;
        foreach (pipe_q[i]) begin
            s.ctrl[8*pipe_q[i].pos +: 8] = pipe_q[i].c;
            s.vld[pipe_q[i].pos]         = 1'b1;
            if (pipe_q[i].pos == S - 1) retire_q.push_back(pipe_q[i].c);
        end
        s.ill = m_ill;
        s.ret = m_ret;
        s.bub = m_bub;
        snap_q.push_back(s);
    endtask

    task automatic tick(input logic r, input logic iv, input logic [OW-1:0] op,
                        input logic st, input logic fl);
        rst          = r;
        bus.in_valid = iv;
        bus.opcode   = op;
        bus.stall    = st;
        bus.flush    = fl;
        @(posedge clk);
        model_step();
        cycle++;
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard
    initial begin
        snap_t      s;
        logic [7:0] exp_c;
        forever begin
            @(negedge clk);
            chk("in_ready", 64'(bus.in_ready), 64'(!bus.stall || bus.flush));
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk("ctrl_stage", 64'(bus.ctrl_stage), 64'(s.ctrl));
                chk("valid_stage", 64'(bus.valid_stage), 64'(s.vld));
                chk("illegal", 64'(bus.illegal), 64'(s.ill));
                chk("retired_cnt", 64'(bus.retired_cnt), 64'(s.ret));
                chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(s.bub));
            end
            if (bus.valid_stage[S-1] === 1'b1) begin
                if (retire_q.size() == 0) begin
                    chk("retire_unexpected", 64'(bus.ctrl_stage[8*(S-1) +: 8]), 64'hdead);
                end else begin
                    exp_c = retire_q.pop_front();
                    chk("retire_word", 64'(bus.ctrl_stage[8*(S-1) +: 8]), 64'(exp_c));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick(1, 0, 4'h0, 0, 0);
        // ADD, LD, ST, JMP stream
        tick(0, 1, 4'b0001, 0, 0);
        tick(0, 1, 4'b1101, 0, 0);
        tick(0, 1, 4'b1010, 0, 0);
        tick(0, 1, 4'b1111, 0, 0);
        repeat (4) tick(0, 0, 4'h0, 0, 0);
        // LD then one stall cycle
        tick(0, 1, 4'b1101, 0, 0);
        tick(0, 1, 4'b0001, 1, 0);
        repeat (3) tick(0, 0, 4'h0, 0, 0);
        // ADD/MUL/XOR in flight, then flush (incoming opcode dropped)
        tick(0, 1, 4'b0100, 0, 0);
        tick(0, 1, 4'b0010, 0, 0);
        tick(0, 1, 4'b0001, 0, 0);
        tick(0, 1, 4'b0011, 0, 1);
        repeat (3) tick(0, 0, 4'h0, 0, 0);
        // stall and flush together
        tick(0, 1, 4'b0001, 0, 0);
        tick(0, 1, 4'b0010, 1, 1);
        repeat (3) tick(0, 0, 4'h0, 0, 0);
        // illegal opcode, and a legal opcode with in_valid low
        tick(0, 1, 4'b0101, 0, 0);
        tick(0, 0, 4'b0001, 0, 0);
        repeat (3) tick(0, 0, 4'h0, 0, 0);
        // enough retirements to wrap retired_cnt past 0xFFFF
        repeat (65540) tick(0, 1, 4'b0001, 0, 0);
        // reset mid-stream
        tick(1, 1, 4'b0001, 0, 0);
        repeat (4) tick(0, 1, 4'b1101, 0, 0);
        // randomized traffic
        repeat (3000) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 OW'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end
        repeat (5) tick(0, 0, 4'h0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(snap_q.size() + retire_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
